// File: rtl/conf_mc_reg_bank.sv
// Multi-channel CONF register bank: round-robin arbitration of NUM_CH valid/ready masters into one
// register file. Optional shadow/commit mode is enabled with `define CONF_SHADOW_EN.
module conf_mc_reg_bank #(
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned NUM_REGS   = 12,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CH-1:0]              c_valid,
   input  logic [NUM_CH*ADDR_WIDTH-1:0]   c_addr,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   c_data,
   output logic [NUM_CH-1:0]              c_ready,
   output logic [NUM_CH-1:0]              c_err,
   input  logic                           c_commit,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_upd
);

   localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic {StIdle, StAck} state_e;

   state_e                  state_q, state_d;
   logic [PTR_W-1:0]        ptr_q, ptr_d;
   logic [PTR_W-1:0]        grant_q, grant_d;
   logic [NUM_CH-1:0]       err_q, err_d;
   logic [NUM_REGS-1:0]     upd_q, upd_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

   logic [PTR_W-1:0]        pick;
   logic                    found;
   logic                    sel_valid;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    addr_ok;
   logic                    wr_en;

   // First requesting channel at or after the pointer, wrapping.
   always_comb begin
      pick  = ptr_q;
      found = 1'b0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (!found && c_valid[c] && (c == (32'(ptr_q) + k) % NUM_CH)) begin
               found = 1'b1;
               pick  = PTR_W'(c);
            end
         end
      end
   end

   // Address and data are taken from the granted channel at the handshake edge.
   always_comb begin
      sel_valid = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (32'(grant_q) == c) begin
            sel_valid = c_valid[c];
            sel_addr  = c_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data  = c_data[c*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      addr_ok = (32'(sel_addr) < NUM_REGS);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      err_d   = '0;
      wr_en   = 1'b0;
      case (state_q)
         StIdle: begin
            if (found) begin
               grant_d = pick;
               state_d = StAck;
            end
         end
         StAck: begin
            state_d = StIdle;
            ptr_d   = (32'(grant_q) + 1 >= NUM_CH) ? '0 : grant_q + PTR_W'(1);
            if (sel_valid) begin
               if (addr_ok) begin
                  wr_en = 1'b1;
               end else begin
                  for (int unsigned c = 0; c < NUM_CH; c++) begin
                     err_d[c] = (32'(grant_q) == c);
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      c_ready = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         c_ready[c] = (state_q == StAck) && (32'(grant_q) == c);
      end
   end

`ifdef CONF_SHADOW_EN
   logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] shadow_d [NUM_REGS];

   // Commit copies the pre-write shadow; a same-edge write stays pending in shadow.
   always_comb begin
      upd_d = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         regs_d[r]   = regs_q[r];
         shadow_d[r] = shadow_q[r];
         if (c_commit) begin
            regs_d[r] = shadow_q[r];
            upd_d[r]  = (shadow_q[r] != regs_q[r]);
         end
         if (wr_en && (32'(sel_addr) == r)) begin
            shadow_d[r] = sel_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            shadow_q[r] <= RESET_VAL;
         end
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            shadow_q[r] <= shadow_d[r];
         end
      end
   end
`else
   logic unused_commit;
   assign unused_commit = c_commit;

   always_comb begin
      upd_d = '0;
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = regs_q[r];
         if (wr_en && (32'(sel_addr) == r)) begin
            regs_d[r] = sel_data;
            upd_d[r]  = 1'b1;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         grant_q <= '0;
         err_q   <= '0;
         upd_q   <= '0;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= RESET_VAL;
         end
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         err_q   <= err_d;
         upd_q   <= upd_d;
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   assign c_err   = err_q;
   assign reg_upd = upd_q;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_out
      assign reg_out[r*DATA_WIDTH +: DATA_WIDTH] = regs_q[r];
   end

endmodule

// File: tb/tb_conf_mc_reg_bank.sv
// Self-checking bench for conf_mc_reg_bank: vector table, directed corner sequences and
// randomized writes against an array model of the register file (shadow model when CONF_SHADOW_EN).
module tb_conf_mc_reg_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  c_valid;
   logic [7:0]  c_addr;
   logic [15:0] c_data;
   logic [1:0]  c_ready;
   logic [1:0]  c_err;
   logic        c_commit;
   logic [95:0] reg_out;
   logic [11:0] reg_upd;

   int checks = 0;
   int errors = 0;

   logic [7:0] exp_regs [12];
   logic [7:0] exp_shadow [12];

   typedef struct {
      int         ch;
      logic [3:0] addr;
      logic [7:0] data;
      logic [1:0] err;
      logic [11:0] upd;
   } vec_t;

   conf_mc_reg_bank #(
      .NUM_CH(2), .ADDR_WIDTH(4), .DATA_WIDTH(8), .NUM_REGS(12), .RESET_VAL(8'h00)
   ) dut (
      .clk(clk), .rst_n(rst_n), .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data),
      .c_ready(c_ready), .c_err(c_err), .c_commit(c_commit), .reg_out(reg_out),
      .reg_upd(reg_upd)
   );

   always #5 clk = ~clk;

   function automatic logic [95:0] model_out();
      logic [95:0] v;
      for (int r = 0; r < 12; r++) v[r*8 +: 8] = exp_regs[r];
      return v;
   endfunction

   task automatic model_reset();
      for (int r = 0; r < 12; r++) begin
         exp_regs[r]   = 8'h00;
         exp_shadow[r] = 8'h00;
      end
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input logic [3:0] addr, input logic [7:0] data);
      c_addr[ch*4 +: 4] = addr;
      c_data[ch*8 +: 8] = data;
      c_valid[ch]       = 1'b1;
   endtask

   // Called 1 time unit after the handshake edge of channel ch.
   task automatic handshake_done(input int ch, input logic [3:0] addr, input logic [7:0] data,
                                 input logic [1:0] exp_err, input logic [11:0] exp_upd,
                                 input string name);
      logic [11:0] upd;
      upd = exp_upd;
      c_valid[ch] = 1'b0;
      check({name, "_ready_fall"}, c_ready, 2'b00);
      if (addr < 12) begin
`ifdef CONF_SHADOW_EN
         exp_shadow[addr] = data;
         upd = '0;
`else
         exp_regs[addr] = data;
`endif
      end
      check({name, "_err"}, c_err, exp_err);
      check({name, "_upd"}, reg_upd, upd);
      check({name, "_regs"}, reg_out, model_out());
      tick();
      check({name, "_err_clr"}, c_err, 2'b00);
      check({name, "_upd_clr"}, reg_upd, 12'h000);
   endtask

   task automatic do_write(input int ch, input logic [3:0] addr, input logic [7:0] data,
                           input logic [1:0] exp_err, input logic [11:0] exp_upd,
                           input string name);
      logic [1:0] oh;
      oh = (ch == 0) ? 2'b01 : 2'b10;
      drive(ch, addr, data);
      tick();
      check({name, "_ready"}, c_ready, oh);
      tick();
      handshake_done(ch, addr, data, exp_err, exp_upd, name);
   endtask

   task automatic commit(input string name);
      logic [11:0] upd;
      upd = '0;
      for (int r = 0; r < 12; r++) begin
         if (exp_regs[r] != exp_shadow[r]) upd[r] = 1'b1;
         exp_regs[r] = exp_shadow[r];
      end
      c_commit = 1'b1;
      tick();
      c_commit = 1'b0;
      check({name, "_upd"}, reg_upd, upd);
      check({name, "_regs"}, reg_out, model_out());
   endtask

   vec_t vecs [7];

   initial begin
      int          grants [$];
      int          hs;
      int          idx [2];
      logic [1:0]  prev;
      logic [3:0]  ra;
      logic [7:0]  rd;
      int          rc;
      logic [1:0]  re;
      logic [11:0] ru;

      vecs[0] = '{0, 4'd0,  8'h5A, 2'b00, 12'h001};
      vecs[1] = '{1, 4'd11, 8'hC3, 2'b00, 12'h800};
      vecs[2] = '{0, 4'd12, 8'h99, 2'b01, 12'h000};
      vecs[3] = '{1, 4'd15, 8'h01, 2'b10, 12'h000};
      vecs[4] = '{1, 4'd7,  8'h00, 2'b00, 12'h080};
      vecs[5] = '{0, 4'd0,  8'h5A, 2'b00, 12'h001};
      vecs[6] = '{1, 4'd10, 8'hE7, 2'b00, 12'h400};

      rst_n = 1'b0; c_valid = '0; c_addr = '0; c_data = '0; c_commit = 1'b0;
      model_reset();
      #1;
      check("rst_ready", c_ready, 2'b00);
      check("rst_regs", reg_out, 96'h0);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      check("idle_ready", c_ready, 2'b00);
      check("idle_err", c_err, 2'b00);
      check("idle_upd", reg_upd, 12'h000);
      check("idle_regs", reg_out, 96'h0);

`ifdef CONF_SHADOW_EN
      // Write and commit on the same edge: commit sees the old shadow value.
      drive(0, 4'd0, 8'h77);
      tick();
      check("sh_ready", c_ready, 2'b01);
      c_commit = 1'b1;
      tick();
      c_commit = 1'b0;
      c_valid[0] = 1'b0;
      exp_shadow[0] = 8'h77;
      check("sh_same_edge_reg0", reg_out[7:0], 8'h00);
      check("sh_same_edge_upd", reg_upd, 12'h000);
      commit("sh_commit");
      check("sh_commit_reg0", reg_out[7:0], 8'h77);
`endif

      do_write(0, 4'd3, 8'hA5, 2'b00, 12'h008, "wr_a5");
      do_write(1, 4'd13, 8'hFF, 2'b10, 12'h000, "err_ch1");

      // Both channels request continuously; grants must alternate.
      idx[0] = 0; idx[1] = 0; hs = 0; prev = 2'b00;
      drive(0, 4'd1, 8'h11);
      drive(1, 4'd2, 8'h21);
      for (int cyc = 0; cyc < 40 && hs < 4; cyc++) begin
         tick();
         for (int c = 0; c < 2; c++) begin
            if (prev[c]) begin
               hs++;
               idx[c]++;
               if (idx[c] == 2) c_valid[c] = 1'b0;
               else c_data[c*8 +: 8] = (c == 0) ? 8'h12 : 8'h22;
            end
         end
         if (c_ready == 2'b01) grants.push_back(0);
         else if (c_ready == 2'b10) grants.push_back(1);
         prev = c_ready;
      end
      c_valid = '0;
      check("alt_handshakes", hs, 4);
      check("alt_grant_count", grants.size(), 4);
      if (grants.size() == 4) begin
         check("alt_grants", {grants[0][3:0], grants[1][3:0], grants[2][3:0], grants[3][3:0]},
               16'h0101);
      end
`ifdef CONF_SHADOW_EN
      exp_shadow[1] = 8'h12; exp_shadow[2] = 8'h22;
      commit("alt_commit");
`else
      exp_regs[1] = 8'h12; exp_regs[2] = 8'h22;
      tick();
`endif
      check("alt_regs", reg_out, model_out());

      // ch0 withdraws during its ready cycle; ch1 then wins over a re-requesting ch0.
      drive(0, 4'd6, 8'h66);
      tick();
      check("wd_ready", c_ready, 2'b01);
      c_valid[0] = 1'b0;
      tick();
      check("wd_ready_fall", c_ready, 2'b00);
      check("wd_err", c_err, 2'b00);
      check("wd_upd", reg_upd, 12'h000);
      check("wd_regs", reg_out, model_out());
      c_valid[0] = 1'b1;
      do_write(1, 4'd4, 8'h44, 2'b00, 12'h010, "wd_ch1");
      check("wd_ch0_ready", c_ready, 2'b01);
      tick();
      handshake_done(0, 4'd6, 8'h66, 2'b00, 12'h040, "wd_ch0");

      // Reset while acknowledging ch0 aborts the write.
      drive(0, 4'd5, 8'h3C);
      tick();
      check("ra_ready", c_ready, 2'b01);
      rst_n = 1'b0;
      #1;
      check("ra_ready_drop", c_ready, 2'b00);
      c_valid = '0;
      model_reset();
      check("ra_regs", reg_out, model_out());
      check("ra_reg5", reg_out[47:40], 8'h00);
      tick();
      rst_n = 1'b1;
      tick();
      check("ra_idle_upd", reg_upd, 12'h000);

      for (int i = 0; i < 7; i++) begin
         do_write(vecs[i].ch, vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].upd, "vec");
      end
`ifdef CONF_SHADOW_EN
      commit("vec_commit");
`endif

      for (int i = 0; i < 60; i++) begin
         rc = $urandom_range(0, 1);
         ra = 4'($urandom_range(0, 15));
         rd = 8'($urandom);
         re = (ra < 12) ? 2'b00 : ((rc == 0) ? 2'b01 : 2'b10);
         ru = (ra < 12) ? (12'h001 << ra) : 12'h000;
         do_write(rc, ra, rd, re, ru, "rnd");
         repeat ($urandom_range(0, 2)) tick();
      end
`ifdef CONF_SHADOW_EN
      commit("rnd_commit");
`endif
      check("final_regs", reg_out, model_out());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
